board_tile_scheduler: RTL and testbench

Sequences the single shared tile renderer, block_vga_module, across the 4x4 2048 board during VGA scan-out. For each pixel it decodes which tile the beam is on and presents that tile's state plus tile-local h/v coordinates to the renderer. It delay-matches the renderer's pixel output and composites it with gap, background and blanking colours. Board updates are accepted through a valid/ready handshake and applied only during vertical blanking, so a frame never tears.

---
 rtl/board_tile_scheduler.sv | 148 ++++++++++++++
 tb/tb_board_tile_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/board_tile_scheduler.sv
// Drives the shared tile renderer across the 4x4 board during scan-out. It also composites
// the renderer output with gap, background and blanking colours, and swaps boards only in vertical blank.
module board_tile_scheduler #(
    parameter logic [11:0] H_ACTIVE    = 12'd640,
    parameter logic [11:0] V_ACTIVE    = 12'd480,
    parameter logic [11:0] BOARD_X0    = 12'd84,
    parameter logic [11:0] BOARD_Y0    = 12'd4,
    parameter logic [11:0] TILE_SIZE   = 12'd108,
    parameter logic [11:0] GAP         = 12'd8,
    parameter int          RENDER_LAT  = 2,
    parameter logic [11:0] BOARD_COLOR = 12'hBAA,
    parameter logic [11:0] BG_COLOR    = 12'hFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] h_cnt,
    input  logic [11:0] v_cnt,
    input  logic [63:0] board_in,
    input  logic        board_valid,
    output logic        board_ready,
    output logic [3:0]  tile_state,
    output logic [11:0] tile_h,
    output logic [11:0] tile_v,
    input  logic [11:0] tile_pix,
    output logic [11:0] vga_data
);

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_GAP  = 2'd1,
        REG_BG   = 2'd2,
        REG_TILE = 2'd3
    } region_t;

    localparam logic [11:0] PITCH   = TILE_SIZE + GAP;
    localparam logic [11:0] BOARD_W = 12'd4 * TILE_SIZE + 12'd5 * GAP;

    logic [63:0] display;
    logic [63:0] pending;
    logic        pending_full;
    logic        commit;

    logic        col_hit, row_hit, in_board;
    logic [1:0]  col_idx, row_idx;
    logic [11:0] col_edge, row_edge;
    region_t     region_d;
    region_t     region_p1;
    region_t     region_dly [RENDER_LAT];

    function automatic logic [11:0] tile_edge(input logic [11:0] base, input logic [1:0] idx);
        return base + GAP + 12'(idx) * PITCH;
    endfunction

    assign board_ready = !pending_full;
    assign commit      = (h_cnt == 12'd0) && (v_cnt == V_ACTIVE) && pending_full;

    // A commit and a transfer are mutually exclusive since ready is low while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (commit) begin
            display      <= pending;
            pending_full <= 1'b0;
        end else if (board_valid && !pending_full) begin
            pending      <= board_in;
            pending_full <= 1'b1;
        end
    end

    always_comb begin
        col_hit  = 1'b0;
        col_idx  = 2'd0;
        col_edge = 12'd0;
        row_hit  = 1'b0;
        row_idx  = 2'd0;
        row_edge = 12'd0;
        for (int i = 0; i < 4; i++) begin
            if (h_cnt >= tile_edge(BOARD_X0, 2'(i)) &&
                h_cnt <  tile_edge(BOARD_X0, 2'(i)) + TILE_SIZE) begin
                col_hit  = 1'b1;
                col_idx  = 2'(i);
                col_edge = tile_edge(BOARD_X0, 2'(i));
            end
            if (v_cnt >= tile_edge(BOARD_Y0, 2'(i)) &&
                v_cnt <  tile_edge(BOARD_Y0, 2'(i)) + TILE_SIZE) begin
                row_hit  = 1'b1;
                row_idx  = 2'(i);
                row_edge = tile_edge(BOARD_Y0, 2'(i));
            end
        end
        in_board = (h_cnt >= BOARD_X0) && (h_cnt < BOARD_X0 + BOARD_W) &&
                   (v_cnt >= BOARD_Y0) && (v_cnt < BOARD_Y0 + BOARD_W);
        region_d = REG_NONE;
        if (h_cnt < H_ACTIVE && v_cnt < V_ACTIVE) begin
            if (col_hit && row_hit) region_d = REG_TILE;
            else if (in_board)      region_d = REG_GAP;
            else                    region_d = REG_BG;
        end
    end

    // Stage 1: tile decode presented to the renderer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            region_p1  <= REG_NONE;
            tile_state <= 4'd0;
            tile_h     <= 12'd0;
            tile_v     <= 12'd0;
        end else begin
            region_p1 <= region_d;
            if (region_d == REG_TILE) begin
                tile_state <= display[{row_idx, col_idx, 2'b00} +: 4];
                tile_h     <= h_cnt - col_edge;
                tile_v     <= v_cnt - row_edge;
            end else begin
                tile_state <= 4'd0;
                tile_h     <= 12'd0;
                tile_v     <= 12'd0;
            end
        end
    end

    // Stages 2..1+RENDER_LAT: region delay matching the renderer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RENDER_LAT; i++) region_dly[i] <= REG_NONE;
        end else begin
            region_dly[0] <= region_p1;
            for (int i = 1; i < RENDER_LAT; i++) region_dly[i] <= region_dly[i-1];
        end
    end

    // Final stage: composite
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_data <= 12'h000;
        end else begin
            case (region_dly[RENDER_LAT-1])
                REG_TILE: vga_data <= tile_pix;
                REG_GAP:  vga_data <= BOARD_COLOR;
                REG_BG:   vga_data <= BG_COLOR;
                default:  vga_data <= 12'h000;
            endcase
        end
    end

endmodule

// File: tb/tb_board_tile_scheduler.sv
// Directed bench for board_tile_scheduler: handshake, vblank commit, tile decode
// boundaries and end-to-end composite through a two-stage renderer stub.
module tb_board_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] h_cnt, v_cnt;
    logic [63:0] board_in;
    logic        board_valid;
    logic        board_ready;
    logic [3:0]  tile_state;
    logic [11:0] tile_h, tile_v, tile_pix, vga_data;
    logic [11:0] pix_d1 = 12'h000;
    logic [11:0] pix_d2 = 12'h000;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [63:0] B1 = 64'h0000_0000_0030_0000;  // tile 5 = 3
    localparam logic [63:0] B2 = 64'h0000_0000_0070_000A;  // tile 5 = 7, tile 0 = A
    localparam logic [63:0] B3 = 64'h0000_0000_00F0_0000;  // tile 5 = F

    board_tile_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .board_in    (board_in),
        .board_valid (board_valid),
        .board_ready (board_ready),
        .tile_state  (tile_state),
        .tile_h      (tile_h),
        .tile_v      (tile_v),
        .tile_pix    (tile_pix),
        .vga_data    (vga_data)
    );

    always #5 clk = ~clk;

    // Renderer stub with RENDER_LAT = 2
    always_ff @(posedge clk) begin
        pix_d1 <= {tile_h[3:0], tile_v[3:0], tile_state};
        pix_d2 <= pix_d1;
    end
    assign tile_pix = pix_d2;

    task automatic check_vec(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe_tile(input string tag, input logic [11:0] h, input logic [11:0] v,
                              input logic [3:0] exp_state);
        h_cnt = h;
        v_cnt = v;
        step();
        check_vec(tag, {8'd0, tile_state}, {8'd0, exp_state});
    endtask

    // Pixel stream: h, v, expected tile_state/tile_h/tile_v one cycle later, vga four later
    localparam int N = 10;
    logic [11:0] sh  [N] = '{12'd91, 12'd92, 12'd93, 12'd199, 12'd200, 12'd0, 12'd700, 12'd84, 12'd216, 12'd216};
    logic [11:0] sv  [N] = '{12'd20, 12'd20, 12'd20, 12'd20,  12'd20,  12'd20, 12'd20, 12'd4,  12'd212, 12'd11};
    logic [3:0]  ets [N] = '{4'h0,   4'hA,   4'hA,   4'hA,    4'h0,    4'h0,   4'h0,   4'h0,   4'h7,    4'h0};
    logic [11:0] eth [N] = '{12'd0,  12'd0,  12'd1,  12'd107, 12'd0,   12'd0,  12'd0,  12'd0,  12'd8,   12'd0};
    logic [11:0] etv [N] = '{12'd0,  12'd8,  12'd8,  12'd8,   12'd0,   12'd0,  12'd0,  12'd0,  12'd84,  12'd0};
    logic [11:0] ev  [N] = '{12'hBAA, 12'h08A, 12'h18A, 12'hB8A, 12'hBAA, 12'hFFE, 12'h000, 12'hBAA, 12'h847, 12'hBAA};

    initial begin
        rst = 1'b1;
        board_valid = 1'b0;
        board_in = 64'd0;
        h_cnt = 12'd0;
        v_cnt = 12'd0;
        #12;
        check_vec("rst_ready", {11'd0, board_ready}, 12'd1);
        check_vec("rst_state", {8'd0, tile_state}, 12'd0);
        check_vec("rst_tile_h", tile_h, 12'd0);
        check_vec("rst_tile_v", tile_v, 12'd0);
        check_vec("rst_vga", vga_data, 12'h000);
        rst = 1'b0;

        // Idle frame: empty board, tile (c=1, r=1)
        h_cnt = 12'd216;
        v_cnt = 12'd212;
        step();
        check_vec("idle_state", {8'd0, tile_state}, 12'd0);
        check_vec("idle_tile_h", tile_h, 12'd8);
        check_vec("idle_tile_v", tile_v, 12'd84);
        check_vec("idle_ready", {11'd0, board_ready}, 12'd1);
        h_cnt = 12'd84;
        v_cnt = 12'd4;
        repeat (4) step();
        check_vec("edge_gap_vga", vga_data, 12'hBAA);

        // Mid-frame transfer; second board held while pending is full
        h_cnt = 12'd300;
        v_cnt = 12'd100;
        board_in = B1;
        board_valid = 1'b1;
        step();
        board_in = B2;
        check_vec("xfer_ready_low", {11'd0, board_ready}, 12'd0);
        probe_tile("no_tear_state", 12'd216, 12'd212, 4'h0);
        repeat (2) step();
        check_vec("held_ready_low", {11'd0, board_ready}, 12'd0);

        // Vblank commit, then second board accepted on the next cycle
        h_cnt = 12'd0;
        v_cnt = 12'd480;
        step();
        check_vec("commit_ready", {11'd0, board_ready}, 12'd1);
        h_cnt = 12'd1;
        step();
        board_valid = 1'b0;
        check_vec("xfer2_ready_low", {11'd0, board_ready}, 12'd0);
        probe_tile("b1_tile5", 12'd216, 12'd212, 4'h3);
        probe_tile("b1_tile0", 12'd100, 12'd20, 4'h0);
        h_cnt = 12'd0;
        v_cnt = 12'd480;
        step();
        check_vec("commit2_ready", {11'd0, board_ready}, 12'd1);
        probe_tile("b2_tile5", 12'd216, 12'd212, 4'h7);

        // Boundary sweep and composite through the renderer stub
        for (int j = 0; j < N + 3; j++) begin
            if (j < N) begin
                h_cnt = sh[j];
                v_cnt = sv[j];
            end
            step();
            if (j < N) begin
                check_vec($sformatf("state[%0d]", j), {8'd0, tile_state}, {8'd0, ets[j]});
                check_vec($sformatf("tile_h[%0d]", j), tile_h, eth[j]);
                check_vec($sformatf("tile_v[%0d]", j), tile_v, etv[j]);
            end
            if (j >= 3) check_vec($sformatf("vga[%0d]", j - 3), vga_data, ev[j-3]);
        end

        // Reset mid-frame with a board pending
        h_cnt = 12'd300;
        v_cnt = 12'd100;
        board_in = B3;
        board_valid = 1'b1;
        step();
        board_valid = 1'b0;
        check_vec("b3_ready_low", {11'd0, board_ready}, 12'd0);
        h_cnt = 12'd216;
        v_cnt = 12'd212;
        repeat (4) step();
        check_vec("pre_rst_vga", vga_data, 12'h847);
        #1 rst = 1'b1;
        #1;
        check_vec("async_rst_vga", vga_data, 12'h000);
        check_vec("async_rst_ready", {11'd0, board_ready}, 12'd1);
        check_vec("async_rst_state", {8'd0, tile_state}, 12'd0);
        #1 rst = 1'b0;
        probe_tile("post_rst_tile5", 12'd216, 12'd212, 4'h0);
        h_cnt = 12'd0;
        v_cnt = 12'd480;
        step();
        probe_tile("no_stale_commit", 12'd216, 12'd212, 4'h0);
        check_vec("post_rst_ready", {11'd0, board_ready}, 12'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
